// File: rtl/pulsed_dds_pkg.sv
// Shared types, pipeline depth and the sine amplitude rule for the pulsed DDS source.
package pulsed_dds_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int PIPE_LAT = 2;

  // round((2^(dw-1)-1) * sin(2*pi*k / 2^addr_bits)), rounding half away from zero
  function automatic int lut_amp(input int k, input int addr_bits, input int dw);
    real amp;
    real v;
    amp = real'((1 << (dw - 1)) - 1);
    v = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(1 << addr_bits));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/sine_lut_rom.sv
// Full-cycle sine table with a registered read port (1-cycle latency).
module sine_lut_rom
  import pulsed_dds_pkg::*;
#(
  parameter int LUT_ADDR_BITS = 8,
  parameter int DW            = 16
) (
  input  logic                     clk,
  input  logic [LUT_ADDR_BITS-1:0] addr_i,
  output logic signed [DW-1:0]     sample_o
);

  localparam int DEPTH = 1 << LUT_ADDR_BITS;

  logic signed [DW-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int AMP = lut_amp(k, LUT_ADDR_BITS, DW);
    assign rom[k] = AMP[DW-1:0];
  end

  always_ff @(posedge clk) begin
    sample_o <= rom[addr_i];
  end

endmodule

// File: rtl/pulsed_dds_gen.sv
// Gated DDS sine-burst generator: one sample per SAMP_DIV clocks, outputs land PIPE_LAT cycles
// after the internal strobe. Pulse width/interval and tuning word apply only at period starts.
module pulsed_dds_gen
  import pulsed_dds_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int SAMP_DIV      = 100,
  parameter int PHASE_W       = 24,
  parameter int LUT_ADDR_BITS = 8,
  parameter int DW            = 16,
  parameter int TIME_W        = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 cfg_load_i,
  input  logic [PHASE_W-1:0]   ftw_i,
  input  logic [TIME_W-1:0]    pw_i,
  input  logic [TIME_W-1:0]    pri_i,
  output logic signed [DW-1:0] data_o,
  output logic                 valid_o,
  output logic                 gate_o,
  output logic                 pulse_start_o,
  output logic                 cfg_pending_o
);

  localparam int DIV_W = $clog2(SAMP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMP_DIV - 1);

  // Strobe spacing must exceed the pipeline depth so valid_o stays a single-cycle pulse.
  if (SAMP_DIV < 2 * PIPE_LAT || CLK_FREQ < SAMP_DIV) begin : g_param_check
    $error("pulsed_dds_gen: SAMP_DIV must be >= 4 and no larger than CLK_FREQ");
  end

  state_t               state;
  logic [DIV_W-1:0]     div;
  logic [TIME_W-1:0]    idx, pw_sh, pri_sh, pw_act, pri_act;
  logic [PHASE_W-1:0]   phase, ftw_sh, ftw_act;
  logic                 s1_vld, s1_gate, s1_start;
  logic signed [DW-1:0] lut_q;

  logic                 strobe, wrap;
  logic [PHASE_W-1:0]   ftw_src, ftw_eff, phase_eff, phase_nxt;
  logic [TIME_W-1:0]    pw_src, pri_src, pw_eff, pri_eff, idx_nxt;
  logic [TIME_W:0]      idx_p1;
  logic                 gate, start;

  always_comb begin
    strobe    = (state == RUN) && en_i && (div == DIV_LAST);
    wrap      = strobe && (idx == '0);
    // A load landing on a period start bypasses the shadow registers.
    ftw_src   = cfg_load_i ? ftw_i : ftw_sh;
    pw_src    = cfg_load_i ? pw_i  : pw_sh;
    pri_src   = cfg_load_i ? pri_i : pri_sh;
    ftw_eff   = wrap ? ftw_src : ftw_act;
    pw_eff    = wrap ? pw_src  : pw_act;
    pri_eff   = wrap ? pri_src : pri_act;
    gate      = (pri_eff != '0) && (idx < pw_eff);
    start     = (pri_eff != '0) && (idx == '0);
    phase_eff = (idx == '0) ? '0 : phase;
    phase_nxt = gate ? phase_eff + ftw_eff : phase_eff;
    idx_p1    = {1'b0, idx} + {{TIME_W{1'b0}}, 1'b1};
    idx_nxt   = (idx_p1 >= {1'b0, pri_eff}) ? '0 : idx_p1[TIME_W-1:0];
  end

  sine_lut_rom #(
    .LUT_ADDR_BITS(LUT_ADDR_BITS),
    .DW           (DW)
  ) u_rom (
    .clk     (clk),
    .addr_i  (phase_eff[PHASE_W-1 -: LUT_ADDR_BITS]),
    .sample_o(lut_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      div           <= '0;
      idx           <= '0;
      phase         <= '0;
      ftw_sh        <= '0;
      pw_sh         <= '0;
      pri_sh        <= '0;
      ftw_act       <= '0;
      pw_act        <= '0;
      pri_act       <= '0;
      cfg_pending_o <= 1'b0;
      s1_vld        <= 1'b0;
      s1_gate       <= 1'b0;
      s1_start      <= 1'b0;
      valid_o       <= 1'b0;
      gate_o        <= 1'b0;
      pulse_start_o <= 1'b0;
      data_o        <= '0;
    end else begin
      if (cfg_load_i) begin
        ftw_sh        <= ftw_i;
        pw_sh         <= pw_i;
        pri_sh        <= pri_i;
        cfg_pending_o <= 1'b1;
      end
      s1_vld        <= strobe;
      s1_gate       <= gate;
      s1_start      <= start;
      // Dropping en_i flushes whatever is still in flight.
      valid_o       <= s1_vld & en_i;
      gate_o        <= s1_vld & s1_gate & en_i;
      pulse_start_o <= s1_vld & s1_start & en_i;
      data_o        <= (s1_vld && s1_gate && en_i) ? lut_q : '0;
      case (state)
        IDLE: begin
          if (en_i) begin
            state         <= RUN;
            div           <= '0;
            idx           <= '0;
            phase         <= '0;
            ftw_act       <= ftw_src;
            pw_act        <= pw_src;
            pri_act       <= pri_src;
            cfg_pending_o <= 1'b0;
          end
        end
        RUN: begin
          if (!en_i) begin
            state <= IDLE;
          end else begin
            div <= strobe ? '0 : div + DIV_W'(1);
            if (strobe) begin
              idx   <= idx_nxt;
              phase <= phase_nxt;
            end
            if (wrap) begin
              ftw_act       <= ftw_eff;
              pw_act        <= pw_eff;
              pri_act       <= pri_eff;
              cfg_pending_o <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
